// File: rtl/rv_gpr_pkg.sv
// Shared GPR/writeback constants and the writeback source encoding used by
// the writeback arbiter and its round-robin grant unit.
package rv_gpr_pkg;

   localparam int XLEN       = 32;
   localparam int GPR_ADDR_W = 5;
   localparam int WB_NUM_REQ = 3;
   localparam int SB_CNT_W   = 2;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_LSU = 2'd1,
      WB_MDU = 2'd2
   } wb_src_e;

endpackage

// File: rtl/rv_rr_arbiter.sv
// Combinational round-robin grant: scans requesters starting at ptr and
// grants the first one found, producing a one-hot (or all-zero) grant.
module rv_rr_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt
);

   logic             found;
   int               sum;
   logic [PTR_W-1:0] idx;

   // ptr is always kept below NUM_REQ, so one conditional wrap is enough
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      sum   = 0;
      idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum = int'(ptr) + i;
         if (sum >= NUM_REQ) sum = sum - NUM_REQ;
         idx = PTR_W'(sum);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rv_wb_arb.sv
// GPR writeback arbiter with registered write port and an optional
// per-register pending scoreboard (built when RV_WB_SCOREBOARD_EN is defined).
module rv_wb_arb
   import rv_gpr_pkg::*;
#(
   parameter int NUM_REQ  = rv_gpr_pkg::WB_NUM_REQ,
   parameter int SB_CNT_W = rv_gpr_pkg::SB_CNT_W
) (
   input  logic                                 clk_i,
   input  logic                                 arstn_i,
   input  logic [NUM_REQ-1:0]                   req_valid_i,
   input  logic [NUM_REQ-1:0][GPR_ADDR_W-1:0]   req_addr_i,
   input  logic [NUM_REQ-1:0][XLEN-1:0]         req_data_i,
   output logic [NUM_REQ-1:0]                   req_ready_o,
   output logic                                 wr_en_o,
   output logic [GPR_ADDR_W-1:0]                wr_addr_o,
   output logic [XLEN-1:0]                      wr_data_o,
   input  logic                                 issue_en_i,
   input  logic [GPR_ADDR_W-1:0]                issue_addr_i,
   output logic                                 issue_stall_o,
   input  logic [GPR_ADDR_W-1:0]                r1_addr_i,
   input  logic [GPR_ADDR_W-1:0]                r2_addr_i,
   output logic                                 r1_busy_o,
   output logic                                 r2_busy_o
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]      rr_ptr;
   logic [NUM_REQ-1:0]    gnt_p0;
   logic                  xfer_p0;
   logic [PTR_W-1:0]      sel_idx_p0;
   logic [GPR_ADDR_W-1:0] sel_addr_p0;
   logic [XLEN-1:0]       sel_data_p0;
   logic                  wr_vld_p1;
   logic [GPR_ADDR_W-1:0] wr_addr_p1;
   logic [XLEN-1:0]       wr_data_p1;

   function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] k);
      if (int'(k) == NUM_REQ - 1) return '0;
      return k + PTR_W'(1);
   endfunction

   rv_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_arbiter (
      .req (req_valid_i),
      .ptr (rr_ptr),
      .gnt (gnt_p0)
   );

   assign req_ready_o = gnt_p0;
   assign xfer_p0     = |gnt_p0;

   // stage p0: mux the granted requester's payload
   always_comb begin
      sel_idx_p0  = '0;
      sel_addr_p0 = '0;
      sel_data_p0 = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_p0[i]) begin
            sel_idx_p0  = PTR_W'(i);
            sel_addr_p0 = req_addr_i[i];
            sel_data_p0 = req_data_i[i];
         end
      end
   end

   // stage p1: registered GPR write port; x0 transfers are consumed silently
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         rr_ptr     <= '0;
         wr_vld_p1  <= 1'b0;
         wr_addr_p1 <= '0;
         wr_data_p1 <= '0;
      end else begin
         wr_vld_p1 <= xfer_p0 && (sel_addr_p0 != '0);
         if (xfer_p0) rr_ptr <= rr_next(sel_idx_p0);
         if (xfer_p0 && (sel_addr_p0 != '0)) begin
            wr_addr_p1 <= sel_addr_p0;
            wr_data_p1 <= sel_data_p0;
         end
      end
   end

   assign wr_en_o   = wr_vld_p1;
   assign wr_addr_o = wr_addr_p1;
   assign wr_data_o = wr_data_p1;

`ifdef RV_WB_SCOREBOARD_EN
   localparam int NREG = 1 << GPR_ADDR_W;

   logic [SB_CNT_W-1:0] cnt [NREG];
   logic                sb_inc;

   function automatic logic [SB_CNT_W-1:0] sat_inc(input logic [SB_CNT_W-1:0] c);
      if (c == '1) return c;
      return c + SB_CNT_W'(1);
   endfunction

   function automatic logic [SB_CNT_W-1:0] sat_dec(input logic [SB_CNT_W-1:0] c);
      if (c == '0) return c;
      return c - SB_CNT_W'(1);
   endfunction

   assign issue_stall_o = (issue_addr_i != '0) && (cnt[issue_addr_i] == '1);
   assign sb_inc        = issue_en_i && (issue_addr_i != '0) && !issue_stall_o;
   assign r1_busy_o     = (r1_addr_i != '0) && (cnt[r1_addr_i] != '0);
   assign r2_busy_o     = (r2_addr_i != '0) && (cnt[r2_addr_i] != '0);

   // x0 is never counted; a simultaneous issue and retire cancel out
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      end else begin
         for (int r = 1; r < NREG; r++) begin
            if (sb_inc && (issue_addr_i == GPR_ADDR_W'(r)) &&
                !(wr_vld_p1 && (wr_addr_p1 == GPR_ADDR_W'(r))))
               cnt[r] <= sat_inc(cnt[r]);
            else if (wr_vld_p1 && (wr_addr_p1 == GPR_ADDR_W'(r)) &&
                     !(sb_inc && (issue_addr_i == GPR_ADDR_W'(r))))
               cnt[r] <= sat_dec(cnt[r]);
         end
      end
   end
`else
   logic unused_sb;

   assign unused_sb     = ^{issue_en_i, issue_addr_i, r1_addr_i, r2_addr_i};
   assign issue_stall_o = 1'b0;
   assign r1_busy_o     = 1'b0;
   assign r2_busy_o     = 1'b0;
`endif

endmodule

// File: doc/rv_wb_arb.md
RV_WB_ARB -- requirements
Module: rv_wb_arb

Interface
REQ-001 The parameter NUM_REQ SHALL default to 3 and set the number of writeback requesters (0=ALU, 1=LSU, 2=MDU).
REQ-002 The parameter SB_CNT_W SHALL default to 2 and set the width of each per-register pending counter.
REQ-003 clk_i  in  1  single clock; all state updates on posedge.
REQ-004 arstn_i  in  1  asynchronous, active-low reset.
REQ-005 req_valid_i  in  NUM_REQ  per-requester writeback valid.
REQ-006 req_addr_i  in  NUM_REQ x GPR_ADDR_W  per-requester destination register.
REQ-007 req_data_i  in  NUM_REQ x XLEN  per-requester writeback data.
REQ-008 req_ready_o  out  NUM_REQ  one-hot grant; a transfer occurs when valid and ready are both high.
REQ-009 wr_en_o / wr_addr_o / wr_data_o  out  1 / GPR_ADDR_W / XLEN  registered GPR write port.
REQ-010 issue_en_i / issue_addr_i  in  1 / GPR_ADDR_W  decode marks a destination as pending.
REQ-011 issue_stall_o  out  1  the pending counter of issue_addr_i is saturated.
REQ-012 r1_addr_i / r2_addr_i  in  GPR_ADDR_W each  operand addresses to check.
REQ-013 r1_busy_o / r2_busy_o  out  1 each  the operand has an outstanding write.

Function
REQ-014 Arbitration SHALL be round-robin: scan starts at pointer rr_ptr; the first valid requester gets req_ready_o in the same cycle (combinational grant).
REQ-015 At most one req_ready_o bit SHALL be high per cycle, and no bit SHALL be high when no request is valid.
REQ-016 After a transfer from requester k, rr_ptr SHALL become (k+1) mod NUM_REQ; with no transfer, rr_ptr SHALL hold.
REQ-017 A transfer SHALL drive wr_en_o=1 with the captured addr/data on the next cycle (latency 1); otherwise wr_en_o=0 and addr/data hold.
REQ-018 A transfer to x0 SHALL be accepted and SHALL produce wr_en_o=0 and no scoreboard change.
REQ-019 The arbiter SHALL accept one transfer per cycle back-to-back, with no bubbles.
REQ-020 Scoreboard: issue_en_i=1 with a nonzero issue_addr_i and issue_stall_o=0 SHALL increment cnt[issue_addr_i].
REQ-021 A cycle with wr_en_o=1 SHALL decrement cnt[wr_addr_o]; the decrement SHALL saturate at 0.
REQ-022 An increment and a decrement to the same register in the same cycle SHALL leave the count unchanged.
REQ-023 issue_stall_o SHALL equal (cnt[issue_addr_i] == 2^SB_CNT_W-1) && issue_addr_i != 0; a stalled issue SHALL not increment.
REQ-024 rN_busy_o SHALL equal (cnt[rN_addr_i] != 0), combinationally; address 0 SHALL never be busy.
REQ-025 Data written by wr_en_o in cycle T SHALL be readable from the GPR in cycle T+1, and busy SHALL drop in T+1 when the count reaches 0.

Reset
REQ-026 The reset SHALL asynchronously set rr_ptr=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, and all counters to 0.
REQ-027 A transfer captured before a mid-operation reset SHALL be discarded, and no write SHALL occur after deassertion.

Configuration
REQ-028 With RV_WB_SCOREBOARD_EN defined, the scoreboard (REQ-020..025) SHALL be built.
REQ-029 Without RV_WB_SCOREBOARD_EN, the counters SHALL be absent, issue_* inputs ignored, and issue_stall_o, r1_busy_o and r2_busy_o tied to 0, with arbitration unchanged.

Structure
REQ-030 rv_gpr_pkg SHALL hold GPR_ADDR_W, WB_NUM_REQ=3, SB_CNT_W=2, and the enum wb_src_e {WB_ALU, WB_LSU, WB_MDU}.
REQ-031 Round-robin grant logic SHALL live in the sub-module rv_rr_arbiter (inputs: req, ptr; output: one-hot gnt).

Verification
REQ-032 Reset, then all three valid with addr 5/6/7 -> grants ALU, LSU, MDU in consecutive cycles, and wr_en_o writes x5, x6, x7 one cycle after each grant.
REQ-033 Only LSU valid, addr 3, data 0xDEADBEEF -> same-cycle ready; next cycle wr_en_o=1, wr_addr_o=3, wr_data_o=0xDEADBEEF.
REQ-034 Transfer to x0, data 0x1234 -> ready=1, then wr_en_o stays 0 and r1_busy_o for addr 0 stays 0.
REQ-035 Issue x9 three times -> issue_stall_o=1 on the fourth issue; three x9 writebacks -> r1_busy_o(x9) drops the cycle after the third wr_en_o.
REQ-036 Issue x4 in the same cycle that wr_en_o writes x4 with count 1 -> count stays 1 and busy stays 1.
REQ-037 Assert arstn_i low in the cycle after a transfer -> wr_en_o=0 immediately, all counters 0, and rr_ptr=0.
